// File: rtl/mod_cu_if.sv
`default_nettype none
// ============================================================================
//  Module      : mod_cu_if
//  Description : Signal bundle between the modulus control unit, its
//                requester and the modulus datapath.
//                  start  - request level from the requester
//                  lt     - datapath flag: remainder < b
//                  b_zero - datapath flag: b == 0
//                  state  - 2-bit datapath command (0 INIT, 1 SUB, 2 CMP, 3 DONE)
//                  busy   - operation in progress
//                  done   - result valid, held until start drops
//                  err    - divide-by-zero or timeout, valid while done
//                  quot   - subtraction count (a/b when err = 0)
//                The "slave" modport is the control unit itself; "master" is
//                the environment around it (requester plus datapath).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mod_cu_if #(
    parameter int CNT_W = 32
) ();

    logic             start;
    logic             lt;
    logic             b_zero;
    logic [1:0]       state;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] quot;

    modport slave (
        input  start,
        input  lt,
        input  b_zero,
        output state,
        output busy,
        output done,
        output err,
        output quot
    );

    modport master (
        output start,
        output lt,
        output b_zero,
        input  state,
        input  busy,
        input  done,
        input  err,
        input  quot
    );

endinterface : mod_cu_if
`default_nettype wire

// File: rtl/mod_cu.sv
`default_nettype none
// ============================================================================
//  Module      : mod_cu
//  Description : Control unit for the iterative modulus engine. Accepts a
//                start request over a four-phase level handshake and walks
//                the datapath through load, compare and subtract steps until
//                the remainder drops below b, b is zero, or the subtraction
//                limit is reached. Reports done / err / quot to the requester.
//  Ports       : clk  - sole clock, rising edge
//                rst  - asynchronous, active-high reset
//                bus  - mod_cu_if.slave
//                         in : start, lt, b_zero
//                         out: state[1:0], busy, done, err, quot[CNT_W-1:0]
//  Parameters  : CNT_W    - width of the subtraction counter
//                MAX_ITER - subtraction limit; still remainder >= b at this
//                           count is reported as a timeout error
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_cu #(
    parameter int               CNT_W    = 32,
    parameter logic [CNT_W-1:0] MAX_ITER = '1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    mod_cu_if.slave     bus
);

    // Datapath command encoding driven on bus.state
    localparam logic [1:0] c_CMD_INIT = 2'd0;
    localparam logic [1:0] c_CMD_SUB  = 2'd1;
    localparam logic [1:0] c_CMD_CMP  = 2'd2;
    localparam logic [1:0] c_CMD_DONE = 2'd3;

    localparam logic [CNT_W-1:0] c_QUOT_ZERO = '0;
    localparam logic [CNT_W-1:0] c_QUOT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_CMP  = 3'd2,
        S_SUB  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_quot;
    logic [CNT_W-1:0] w_quot_nxt;
    logic             r_err;
    logic             w_err_nxt;

    // ------------------------------------------------------------------------
    // State, counter and error registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_quot  <= c_QUOT_ZERO;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_quot  <= w_quot_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-value logic
    // quot/err hold by default so that the result survives S_DONE and the
    // following S_IDLE; only S_INIT clears them.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_quot_nxt  = r_quot;
        w_err_nxt   = r_err;

        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_INIT;
                end
            end

            S_INIT: begin
                w_quot_nxt  = c_QUOT_ZERO;
                w_err_nxt   = 1'b0;
                w_state_nxt = S_CMP;
            end

            S_CMP: begin
                // Priority: divide-by-zero, normal finish, then timeout.
                // The timeout test sits ahead of any S_SUB, so quot can
                // never step past MAX_ITER and never wraps.
                if (bus.b_zero) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (bus.lt) begin
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_DONE;
                end else if (r_quot == MAX_ITER) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_SUB;
                end
            end

            S_SUB: begin
                w_quot_nxt  = r_quot + c_QUOT_ONE;
                w_state_nxt = S_CMP;
            end

            S_DONE: begin
                // Entered unconditionally, so residency is at least one
                // cycle even if the requester already released start.
                if (!bus.start) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode: purely from registered state, so nothing on the input
    // side (start, lt, b_zero) reaches an output combinationally.
    // ------------------------------------------------------------------------
    always_comb begin
        bus.state = c_CMD_INIT;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                // INIT command here too: the datapath reloads a, which is
                // harmless because S_INIT reloads it again before use.
                bus.state = c_CMD_INIT;
            end
            S_INIT: begin
                bus.state = c_CMD_INIT;
                bus.busy  = 1'b1;
            end
            S_CMP: begin
                bus.state = c_CMD_CMP;
                bus.busy  = 1'b1;
            end
            S_SUB: begin
                bus.state = c_CMD_SUB;
                bus.busy  = 1'b1;
            end
            S_DONE: begin
                // DONE command freezes the datapath remainder.
                bus.state = c_CMD_DONE;
                bus.done  = 1'b1;
            end
            default: begin
                bus.state = c_CMD_INIT;
            end
        endcase
    end

    assign bus.err  = r_err;
    assign bus.quot = r_quot;

endmodule : mod_cu
`default_nettype wire

// File: doc/mod_cu.md
# mod_cu

Control unit for the iterative modulus engine. Accepts a start request over a four-phase level handshake, and sequences the modulus datapath through load, compare and subtract steps via its 2-bit `state` bus. It consumes the datapath's comparison flags and reports done, error and quotient (subtraction count) to the requester. It sits directly upstream of the modulus datapath and drives that datapath's `state` input.

## Interface
- `CNT_W`, default 32: width of the subtraction counter `quot`.
- `MAX_ITER`, default 2^CNT_W−1: subtraction limit. Reaching it with the remainder still ≥ b is a timeout error.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request level; sampled only in IDLE and DONE.
- `lt`  in  1  datapath flag: current remainder < b (combinational from datapath).
- `b_zero`  in  1  datapath flag: b == 0.
- `state`  out  2  datapath command: 0 = INITIALIZE, 1 = SUBTRACT, 2 = COMPARE, 3 = DONE.
- `busy`  out  1  high in S_INIT, S_CMP and S_SUB.
- `done`  out  1  high while in S_DONE.
- `err`  out  1  registered; valid while `done`=1 (divide-by-zero or timeout).
- `quot`  out  CNT_W  subtraction count; equals a/b when `err`=0.

## Operation
- Internal FSM states, each with its `state` output:
  - S_IDLE → 0
  - S_INIT → 0
  - S_CMP → 2
  - S_SUB → 1
  - S_DONE → 3
- S_IDLE
  - `start`=1 → S_INIT.
  - Otherwise stay.
  - `state`=0 here. The datapath reloads `a` harmlessly.
- S_INIT
  - Datapath loads `a` at the end of this cycle.
  - `quot`←0, `err`←0.
  - Unconditionally → S_CMP.
- S_CMP, priority order:
  - `b_zero`=1 → S_DONE, `err`←1.
  - else `lt`=1 → S_DONE, `err`←0.
  - else `quot`==MAX_ITER → S_DONE, `err`←1.
  - else → S_SUB.
- S_SUB
  - Datapath performs remainder−b.
  - `quot`←`quot`+1. Never wraps, because the S_CMP timeout check precedes any increment past MAX_ITER.
  - → S_CMP.
- S_DONE
  - Hold `state`=3, so the datapath remainder stays frozen; `quot`/`err` also hold.
  - `start`=0 → S_IDLE.
  - `start`=1 → stay.
  - Minimum residency one cycle, even if `start` already fell.
- `start` changes while `busy`=1 are ignored; the operation always runs to S_DONE.
- `lt`/`b_zero` are sampled only in S_CMP; their values elsewhere are don't-care.
- Reset (async, any state): internal state→S_IDLE, `state`=0, `busy`=0, `done`=0, `err`=0, `quot`=0. An in-flight operation is abandoned, with no done pulse.
- After S_DONE→S_IDLE, `quot`/`err` keep their last values until the next S_INIT.

## Timing
- All outputs are registered or decoded from the registered FSM state. There is no combinational path from `start`, `lt` or `b_zero` to any output.
- Let `start` be sampled high in S_IDLE at edge N, and q = number of subtractions performed.
  - `busy` rises after edge N.
  - `done` rises after edge N+2+2q; `busy` falls on the same edge.
  - b=0 or a<b: `done` after N+2, q=0.
- Handshake: requester holds `start` until `done`=1, then drops it.
  - `done` falls after the first edge at which `start`=0 is sampled in S_DONE.
  - A new `start` is accepted no earlier than the edge after S_IDLE is entered, so a back-to-back request costs one S_IDLE cycle.
- Reset deassertion: first `start` sample occurs on the first rising edge with `rst`=0.

## Test plan
- a=17, b=5 (datapath lt model), `start` at edge N → `state` sequence 0,2,1,2,1,2,1,2,3; `done` after N+8; `quot`=3, `err`=0; datapath remainder 2.
- a=3, b=5 → `done` after N+2, `quot`=0, `err`=0; remainder 3.
- b=0, a=9 → `done` after N+2, `err`=1, `quot`=0; `state` never 1.
- MAX_ITER=4, a=100, b=1 → `done` after N+10, `err`=1, `quot`=4.
- Hold `start`=1 for 5 cycles in S_DONE → `done` stays 1 and `state` stays 3; drop `start` → `done`=0 next edge; reassert `start` → new S_INIT with `quot` cleared to 0.
- Assert `rst` mid-S_SUB (a=17, b=5) → immediately `state`=0, `busy`=0, `done`=0, `quot`=0, `err`=0; release `rst` and restart → normal result `quot`=3.
